subneg_ctrl: RTL

//  Control unit of the SUBNEG one-instruction processor. It sequences one shared memory port and the operand/select datapath.
//  Per instruction it fetches the operand addresses A, B, C and reads mem[A] and mem[B].
//  It then writes mem[B] - mem[A] back to B, and branches to C if the result is negative; otherwise it advances PC by 3.

---
 rtl/subneg_pkg.sv | 26 ++
 rtl/subneg_ctrl_if.sv | 32 +++
 rtl/subneg_alu.sv | 14 +
 rtl/subneg_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/subneg_pkg.sv
// Shared types and constants for the SUBNEG control unit.
// Holds the FSM state encoding and the instruction geometry.
package subneg_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int INSTR_WORDS = 3;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH_A = 4'd1,
    FETCH_B = 4'd2,
    FETCH_C = 4'd3,
    LOAD_A  = 4'd4,
    LOAD_B  = 4'd5,
    WRITE   = 4'd6,
    BRANCH  = 4'd7,
    HALT    = 4'd8
  } state_t;

  // States that own the memory port (mem_req is high in exactly these).
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH_A) || (s == FETCH_B) || (s == FETCH_C) ||
           (s == LOAD_A)  || (s == LOAD_B)  || (s == WRITE);
  endfunction

endpackage

// File: rtl/subneg_ctrl_if.sv
// Single-port memory bus between the SUBNEG control unit and its memory.
// Handshake: an access is held (req, we, addr, wdata stable) until the cycle where req && ready; it completes on that edge and rdata is valid in that cycle.
interface subneg_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/subneg_alu.sv
// Subtract-and-test datapath: diff = b - a (wrapping), neg = sign of diff.
module subneg_alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             neg
);

  assign diff = b - a;
  assign neg  = diff[WIDTH-1];

endmodule

// File: rtl/subneg_ctrl.sv
// SUBNEG control unit: sequences fetch of A/B/C, operand loads, write-back of mem[B]-mem[A]
// and the branch-on-negative, over one shared memory port.
module subneg_ctrl
  import subneg_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter logic [WIDTH-1:0] START_PC  = '0,
  parameter logic [WIDTH-1:0] HALT_ADDR = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  subneg_ctrl_if.master    bus,
  output logic [WIDTH-1:0] pc,
  output logic             busy,
  output logic             halted,
  output state_t           state
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] diff;
  logic             neg;
  logic [WIDTH-1:0] next_pc;
  logic             ack;

  subneg_alu #(.WIDTH(WIDTH)) u_alu (
    .a    (opa_q),
    .b    (opb_q),
    .diff (diff),
    .neg  (neg)
  );

  assign next_pc = neg ? c_q : pc_q + WIDTH'(INSTR_WORDS);

  // Address is registered on the transition into each memory state so it is stable while waiting.
  assign bus.mem_req   = is_mem_state(state_q);
  assign bus.mem_we    = (state_q == WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = (state_q == WRITE) ? diff : '0;
  assign ack           = bus.mem_req && bus.mem_ready;

  assign pc     = pc_q;
  assign busy   = (state_q != IDLE) && (state_q != HALT);
  assign halted = (state_q == HALT);
  assign state  = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH_A;
      FETCH_A: if (ack)   state_d = FETCH_B;
      FETCH_B: if (ack)   state_d = FETCH_C;
      FETCH_C: if (ack)   state_d = LOAD_A;
      LOAD_A:  if (ack)   state_d = LOAD_B;
      LOAD_B:  if (ack)   state_d = WRITE;
      WRITE:   if (ack)   state_d = BRANCH;
      BRANCH:  state_d = (next_pc == HALT_ADDR) ? HALT : FETCH_A;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          pc_q   <= START_PC;
          addr_q <= START_PC;
        end
        FETCH_A: if (ack) begin
          a_q    <= bus.mem_rdata;
          addr_q <= pc_q + WIDTH'(1);
        end
        FETCH_B: if (ack) begin
          b_q    <= bus.mem_rdata;
          addr_q <= pc_q + WIDTH'(2);
        end
        FETCH_C: if (ack) begin
          c_q    <= bus.mem_rdata;
          addr_q <= a_q;
        end
        LOAD_A: if (ack) begin
          opa_q  <= bus.mem_rdata;
          addr_q <= b_q;
        end
        LOAD_B: if (ack) begin
          opb_q  <= bus.mem_rdata;
        end
        BRANCH: begin
          pc_q   <= next_pc;
          addr_q <= next_pc;
        end
        default: ;
      endcase
    end
  end

endmodule
